// File: rtl/gl_tri_fifo.sv
// gl_tri_fifo: triangle assembly and buffering stage that feeds the rasterizer.
//
// Groups incoming 96-bit vertices into 288-bit triangles, queues them in a
// circular buffer of 2^DEPTH_LOG2 entries, and issues the head triangle to the
// rasterizer one at a time. After an issue pulse, nothing else is issued until
// the rasterizer signals completion with a rising edge on raster_ready.
//
// Optional feature: define TRI_STRIP_EN for triangle-strip assembly. Every
// vertex after the first two of a strip then emits a triangle. Odd strip
// triangles swap their first two vertices so the winding stays consistent.
// When the macro is undefined, the block assembles independent triangle lists.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   vtx_valid/ready     vertex handshake; vtx_ready = buffer not full
//   vtx_data[95:0]      vertex {x, y, z}, passed through untouched
//   vtx_restart         starts a new triangle (or strip) with this vertex
//   fifo_ready          one-cycle issue pulse for the head triangle
//   fifo_in1..3[95:0]   head triangle vertices (0 when buffer empty)
//   raster_ready        completion from the rasterizer (rising edge pops)
//   tri_count           triangles stored, including the one in flight
//   busy                a triangle is issued and not yet completed
module gl_tri_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vtx_valid,
  output logic                  vtx_ready,
  input  logic [95:0]           vtx_data,
  input  logic                  vtx_restart,
  output logic                  fifo_ready,
  output logic [95:0]           fifo_in1,
  output logic [95:0]           fifo_in2,
  output logic [95:0]           fifo_in3,
  input  logic                  raster_ready,
  output logic [DEPTH_LOG2:0]   tri_count,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef struct packed {
    logic [95:0] v0;
    logic [95:0] v1;
    logic [95:0] v2;
  } tri_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  tri_t                  mem [DEPTH];
  tri_t                  wr_tri;
  tri_t                  head;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [1:0]            idx;
  logic [1:0]            idx_eff;
  logic [95:0]           v0, v1;
  logic                  vtx_acc, wr_en, pop;
  logic                  raster_ready_q;
  state_t                state;

  // A full buffer stalls every vertex, including the first two of a triangle,
  // so a completed triangle always has a free slot.
  assign vtx_ready = (tri_count != FULL_CNT);
  assign vtx_acc   = vtx_valid && vtx_ready;
  // A restart vertex always behaves as the first vertex, whatever was held.
  assign idx_eff   = vtx_restart ? 2'd0 : idx;
  assign wr_en     = vtx_acc && idx_eff[1];
  assign pop       = (state == S_WAIT) && raster_ready && !raster_ready_q;
  assign busy      = (state == S_WAIT);

`ifdef TRI_STRIP_EN
  logic odd;
  // v0/v1 hold the two previous strip vertices in arrival order.
  assign wr_tri = odd ? {v1, v0, vtx_data} : {v0, v1, vtx_data};
`else
  assign wr_tri = {v0, v1, vtx_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin : assemble
    if (!rst_n) begin
      wr_ptr <= '0;
      idx    <= 2'd0;
      v0     <= '0;
      v1     <= '0;
`ifdef TRI_STRIP_EN
      odd    <= 1'b0;
`endif
    end else if (vtx_acc) begin
      case (idx_eff)
        2'd0: begin
          v0  <= vtx_data;
          idx <= 2'd1;
`ifdef TRI_STRIP_EN
          odd <= 1'b0;
`endif
        end
        2'd1: begin
          v1  <= vtx_data;
          idx <= 2'd2;
        end
        default: begin
          wr_ptr <= wr_ptr + PTR_ONE;
`ifdef TRI_STRIP_EN
          // Slide the window; idx stays at 2 so each new vertex emits.
          v0  <= v1;
          v1  <= vtx_data;
          odd <= ~odd;
`else
          idx <= 2'd0;
`endif
        end
      endcase
    end
  end

  // Triangle storage carries no reset; contents are only observed while
  // tri_count says the entry is live.
  always_ff @(posedge clk) begin : store
    if (wr_en) mem[wr_ptr] <= wr_tri;
  end

  assign head     = mem[rd_ptr];
  assign fifo_in1 = (tri_count != '0) ? head.v0 : '0;
  assign fifo_in2 = (tri_count != '0) ? head.v1 : '0;
  assign fifo_in3 = (tri_count != '0) ? head.v2 : '0;

  always_ff @(posedge clk or negedge rst_n) begin : issue_fsm
    if (!rst_n) begin
      state          <= S_IDLE;
      rd_ptr         <= '0;
      tri_count      <= '0;
      raster_ready_q <= 1'b0;
      fifo_ready     <= 1'b0;
    end else begin
      // The previous level is tracked continuously, so an edge that occurred
      // while idle cannot pop a triangle issued later.
      raster_ready_q <= raster_ready;
      fifo_ready     <= 1'b0;
      case ({wr_en, pop})
        2'b10:   tri_count <= tri_count + CNT_ONE;
        2'b01:   tri_count <= tri_count - CNT_ONE;
        default: ;
      endcase
      case (state)
        S_IDLE: begin
          // Include a write on this edge, so a triangle completed into an
          // empty buffer is issued on the very next cycle.
          if (tri_count != '0 || wr_en) begin
            fifo_ready <= 1'b1;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gl_tri_fifo.sv
// Bench for gl_tri_fifo: a queue-level reference model, checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gl_tri_fifo;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vtx_valid = 1'b0;
  logic          vtx_ready;
  logic [95:0]   vtx_data = '0;
  logic          vtx_restart = 1'b0;
  logic          fifo_ready;
  logic [95:0]   fifo_in1, fifo_in2, fifo_in3;
  logic          raster_ready = 1'b0;
  logic [DL:0]   tri_count;
  logic          busy;

  gl_tri_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n), .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
    .vtx_data(vtx_data), .vtx_restart(vtx_restart), .fifo_ready(fifo_ready),
    .fifo_in1(fifo_in1), .fifo_in2(fifo_in2), .fifo_in3(fifo_in3),
    .raster_ready(raster_ready), .tri_count(tri_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [95:0] vx(input logic [31:0] x);
    return {x, x ^ 32'h5a5a_0000, ~x};
  endfunction

  // Reference model: a queue of triangles (front = head, including the one
  // in flight) and the list of vertices in the current primitive.
  logic [287:0] mq[$];
  logic [95:0]  pend[$];
  int           k = 0;
  bit           m_inflight = 0, m_fr = 0, m_rrq = 0;
  logic [95:0]  iss[$];

  initial begin : model
    bit acc, wr, pp, issue;
    logic [287:0] nt;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete(); pend.delete(); k = 0;
        m_inflight = 0; m_fr = 0; m_rrq = 0;
      end else begin
        acc = vtx_valid && (mq.size() != DEPTH);
        wr  = 0;
        nt  = '0;
        if (acc) begin
          if (vtx_restart) begin pend.delete(); k = 0; end
          pend.push_back(vtx_data);
          if (pend.size() == 3) begin
`ifdef TRI_STRIP_EN
            nt = (k % 2 == 1) ? {pend[1], pend[0], pend[2]} : {pend[0], pend[1], pend[2]};
            k++;
            void'(pend.pop_front());
`else
            nt = {pend[0], pend[1], pend[2]};
            pend.delete();
`endif
            wr = 1;
          end
        end
        pp    = m_inflight && raster_ready && !m_rrq;
        issue = !m_inflight && (mq.size() != 0 || wr);
        if (pp) begin void'(mq.pop_front()); m_inflight = 0; end
        if (wr) mq.push_back(nt);
        if (issue) m_inflight = 1;
        m_fr  = issue;
        m_rrq = raster_ready;
      end
    end
  end

  initial begin : compare
    logic [287:0] hd;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        hd = (mq.size() != 0) ? mq[0] : '0;
        chk("cyc_fifo_ready", 288'(fifo_ready), 288'(m_fr));
        chk("cyc_busy", 288'(busy), 288'(m_inflight));
        chk("cyc_tri_count", 288'(tri_count), 288'(mq.size()));
        chk("cyc_vtx_ready", 288'(vtx_ready), 288'(mq.size() != DEPTH));
        chk("cyc_fifo_in", {fifo_in1, fifo_in2, fifo_in3}, hd);
        if (fifo_ready) iss.push_back(fifo_in1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [95:0] d, input logic rs);
    bit ok;
    int t = 0;
    vtx_valid = 1'b1; vtx_data = d; vtx_restart = rs;
    while (1) begin
      ok = vtx_ready;
      @(posedge clk); #1;
      if (ok) break;
      t++;
      if (t > 60) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: got no accept expected accept within 60 cycles");
        break;
      end
    end
    vtx_valid = 1'b0; vtx_restart = 1'b0;
  endtask

  task automatic pulse();
    raster_ready = 1'b1; tick(1); raster_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(1);
  endtask

  initial begin
    tick(1);
    chk("rst_tri_count", 288'(tri_count), 288'(0));
    chk("rst_fifo_ready", 288'(fifo_ready), 288'(0));
    chk("rst_busy", 288'(busy), 288'(0));
    chk("rst_vtx_ready", 288'(vtx_ready), 288'(1));
    chk("rst_fifo_in1", 288'(fifo_in1), 288'(0));
    rst_n = 1'b1; tick(1);

    // Basic issue
    send(vx(32'h3F800000), 1'b0);
    send(vx(32'h40000000), 1'b0);
    send(vx(32'h40400000), 1'b0);
    chk("basic_fifo_ready", 288'(fifo_ready), 288'(1));
    chk("basic_in1_x", 288'(fifo_in1[95:64]), 288'(32'h3F800000));
    chk("basic_in3_x", 288'(fifo_in3[95:64]), 288'(32'h40400000));
    chk("basic_count", 288'(tri_count), 288'(1));
    chk("basic_busy", 288'(busy), 288'(1));
    tick(1);
    chk("basic_pulse_len", 288'(fifo_ready), 288'(0));

    // Completion
    send(vx(32'h40800000), 1'b0);
    send(vx(32'h40A00000), 1'b0);
    send(vx(32'h40C00000), 1'b0);
    chk("cpl_count2", 288'(tri_count), 288'(2));
    pulse();
    chk("cpl_count1", 288'(tri_count), 288'(1));
    chk("cpl_busy0", 288'(busy), 288'(0));
    chk("cpl_no_issue_yet", 288'(fifo_ready), 288'(0));
    chk("cpl_head_x", 288'(fifo_in1[95:64]), 288'(32'h40800000));
    tick(1);
    chk("cpl_reissue", 288'(fifo_ready), 288'(1));
    send(vx(32'h40E00000), 1'b0);
    send(vx(32'h41000000), 1'b0);
    send(vx(32'h41100000), 1'b0);
    raster_ready = 1'b1; tick(5);
    chk("cpl_level_count", 288'(tri_count), 288'(1));
    chk("cpl_level_busy", 288'(busy), 288'(1));
    raster_ready = 1'b0; tick(1);
    pulse();
    chk("cpl_drain", 288'(tri_count), 288'(0));
    tick(2);

    // Full
    do_reset();
    for (int i = 0; i < 12; i++) send(vx(32'h200 + 32'(i)), 1'b0);
    chk("full_count", 288'(tri_count), 288'(4));
    chk("full_vtx_ready", 288'(vtx_ready), 288'(0));
    vtx_valid = 1'b1; vtx_data = vx(32'h20C); tick(3);
    chk("full_hold_count", 288'(tri_count), 288'(4));
    pulse();
    chk("full_pop_count", 288'(tri_count), 288'(3));
    chk("full_pop_ready", 288'(vtx_ready), 288'(1));
    send(vx(32'h20C), 1'b0);
    send(vx(32'h20D), 1'b0);
    send(vx(32'h20E), 1'b0);
    chk("full_refill", 288'(tri_count), 288'(4));
    chk("full_refill_ready", 288'(vtx_ready), 288'(0));

    // Wrap and simultaneous write/pop
    do_reset();
    iss.delete();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++) send(vx(32'h300 + 32'(3 * i + j)), 1'b0);
    tick(1);
    for (int i = 2; i < 7; i++) begin
      send(vx(32'h300 + 32'(3 * i)), 1'b0);
      send(vx(32'h300 + 32'(3 * i + 1)), 1'b0);
      raster_ready = 1'b1;
      send(vx(32'h300 + 32'(3 * i + 2)), 1'b0);
      chk("simul_count", 288'(tri_count), 288'(2));
      raster_ready = 1'b0;
      tick(2);
    end
    pulse(); tick(2); pulse(); tick(2);
    chk("wrap_drained", 288'(tri_count), 288'(0));
    chk("wrap_issues", 288'(iss.size()), 288'(7));
    for (int i = 0; i < 7; i++)
      if (i < iss.size()) chk("wrap_order", 288'(iss[i][95:64]), 288'(32'h300 + 32'(3 * i)));

    // Restart, then reset while busy
    do_reset();
    send(vx(32'h401), 1'b0);
    send(vx(32'h402), 1'b0);
    send(vx(32'h403), 1'b1);
    send(vx(32'h404), 1'b0);
    send(vx(32'h405), 1'b0);
    chk("rs_count", 288'(tri_count), 288'(1));
    chk("rs_issue", 288'(fifo_ready), 288'(1));
    chk("rs_tri", {fifo_in1, fifo_in2, fifo_in3}, {vx(32'h403), vx(32'h404), vx(32'h405)});
    rst_n = 1'b0; #1;
    chk("rb_fifo_ready", 288'(fifo_ready), 288'(0));
    chk("rb_count", 288'(tri_count), 288'(0));
    chk("rb_busy", 288'(busy), 288'(0));
    chk("rb_fifo_in1", 288'(fifo_in1), 288'(0));
    tick(2); rst_n = 1'b1; tick(1);

    // Five vertices: strip gives three triangles, list gives one
    for (int i = 0; i < 5; i++) send(vx(32'h500 + 32'(i)), 1'b0);
`ifdef TRI_STRIP_EN
    chk("strip_count", 288'(tri_count), 288'(3));
    chk("strip_t0", {fifo_in1, fifo_in2, fifo_in3}, {vx(32'h500), vx(32'h501), vx(32'h502)});
    tick(1); pulse();
    chk("strip_t1", {fifo_in1, fifo_in2, fifo_in3}, {vx(32'h502), vx(32'h501), vx(32'h503)});
    tick(1); pulse();
    chk("strip_t2", {fifo_in1, fifo_in2, fifo_in3}, {vx(32'h502), vx(32'h503), vx(32'h504)});
`else
    chk("list_count", 288'(tri_count), 288'(1));
    chk("list_t0", {fifo_in1, fifo_in2, fifo_in3}, {vx(32'h500), vx(32'h501), vx(32'h502)});
`endif
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
